etapa_fetch: RTL
================

Name: etapa_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the instruction decoder. It owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction plus its PC to the decoder through a one-entry valid/ready output register. It also accepts branch/jump redirects from later stages, discarding any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0013, value driven on instr while not valid (addi x0,x0,0).

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
mem_req  out  1  instruction-memory read request.
mem_addr  out  32  word address of the request; equals the current PC.
mem_ack  in  1  memory response strobe; mem_rdata is valid in the same cycle.
mem_rdata  in  32  instruction word returned by memory.
redirect  in  1  one-cycle pulse: load redirect_pc as the new PC.
redirect_pc  in  32  redirect target.
instr_ready  in  1  decoder accepts instr this cycle.
instr_valid  out  1  instr and pc_out hold a valid fetched instruction.
instr  out  32  instruction word sent to the decoder.
pc_out  out  32  address of instr.
fetch_err  out  1  misaligned redirect target; sticky until the next aligned redirect.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, mem_req=0, instr_valid=0, instr=NOP_INSTR, pc_out=0, fetch_err=0. Reset mid-request drops mem_req immediately; memory must tolerate an abandoned request.
- States: IDLE, REQ, DRAIN, ERR.
- IDLE: one cycle after reset release, then REQ.
- REQ:
  - mem_req=1 when (!instr_valid || instr_ready); otherwise mem_req=0 and the stage waits.
  - mem_addr=pc, stable while mem_req=1 and mem_ack=0.
  - Memory may hold ack for any number of cycles.
- Accept:
  - A cycle with mem_req && mem_ack and no redirect captures the response.
  - Next cycle: instr=mem_rdata, pc_out=pc, instr_valid=1, pc=pc+4.
  - Latency is ack cycle N -> instr_valid in N+1.
  - A zero-wait memory (ack in the request cycle) gives 1 instr/cycle while instr_ready=1.
- Transfer: a cycle with instr_valid && instr_ready consumes the entry. If no new ack arrives that cycle, the next cycle has instr_valid=0 and instr=NOP_INSTR.
- Stall: while instr_valid && !instr_ready, instr and pc_out hold and no new request is issued.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (highest priority; any state except during reset):
  - Next cycle: instr_valid=0, instr=NOP_INSTR, pc=redirect_pc.
  - If mem_req=1 and mem_ack=0 in the redirect cycle, go to DRAIN.
  - If mem_ack=1 in the redirect cycle, the returned data is discarded and the stage goes to REQ.
  - If no request is outstanding, go to REQ.
  - Redirect with instr_valid && instr_ready in the same cycle: the transfer completes, then the flush applies.
- DRAIN:
  - mem_req stays 1 and mem_addr keeps the old address until mem_ack; the response is discarded.
  - Then REQ at the new pc.
  - A second redirect during DRAIN overwrites pc; the stage stays in DRAIN.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - fetch_err=1 next cycle; go to ERR (or DRAIN first if a request is outstanding, then ERR).
  - ERR: mem_req=0, instr_valid=0.
  - An aligned redirect clears fetch_err and goes to REQ; a misaligned one keeps ERR.
- Outputs are registered except mem_req and mem_addr, which are derived from state/pc and have no combinational path from mem_ack.

Decomposition:
- Shared package holds: state encoding (IDLE/REQ/DRAIN/ERR), the NOP_INSTR constant (32'h0000_0013), the default RESET_PC, and the word-increment constant 4.
- Sub-module: pc_reg (PC register with async active-low reset, +4 increment, redirect load). Everything else stays in etapa_fetch.

Test Plan:
- Reset release, zero-wait memory returning 32'hFD01_0113 at 0, instr_ready=1 -> mem_addr 0,4,8 on consecutive cycles; instr=32'hFD01_0113 with pc_out=0 one cycle after ack.
- Memory ack delayed 3 cycles at addr 4 -> mem_addr=4 held stable for all 3 cycles; instr_valid asserted only after ack.
- instr_ready=0 for 5 cycles with instr_valid=1 -> instr and pc_out frozen, mem_req=0; ready=1 resumes at the next pc.
- Redirect to 32'h0000_0100 while a request to 8 is unacked -> DRAIN keeps mem_addr=8 until ack, data discarded; next request at 0x100; instr_valid never shows the address-8 data.
- Redirect to 32'h0000_0102 -> fetch_err=1, mem_req=0; then redirect to 0x200 -> fetch_err=0, fetch at 0x200.
- Redirect to 32'hFFFF_FFFC, two fetches -> pc_out FFFF_FFFC then 0000_0000; assert reset mid-wait -> all outputs at reset values immediately.

Source files
------------

// File: rtl/etapa_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and constants.
// No logic; no latency; no flow control.
package etapa_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/etapa_fetch_pc_reg.sv
// Program counter: redirect load has priority over the +4 word increment.
// Updates one cycle after load/inc; no backpressure of its own.
// Wraps modulo 2^32.
module etapa_fetch_pc_reg
    import etapa_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + PC_INC;
        end
    end

endmodule

// File: rtl/etapa_fetch.sv
// Instruction fetch: owns the PC, reads memory over req/ack, hands words to the decoder.
// Ack in cycle N -> instr_valid in N+1; zero-wait memory sustains one instruction per cycle.
// Output register stalls on !instr_ready and no new request is issued until it drains.
module etapa_fetch
    import etapa_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  drain_addr;
    logic         outstanding;
    logic         accept;
    logic         xfer;
    logic         redir_bad;

    // Requests depend only on state, pc and the output register, never on mem_ack.
    assign mem_req  = (state == ST_DRAIN) ||
                      ((state == ST_REQ) && (!instr_valid || instr_ready));
    assign mem_addr = (state == ST_DRAIN) ? drain_addr : pc;

    assign outstanding = mem_req && !mem_ack;
    assign accept      = (state == ST_REQ) && mem_req && mem_ack && !redirect;
    assign xfer        = instr_valid && instr_ready;
    assign redir_bad   = pc_misaligned(redirect_pc);

    etapa_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (redirect),
        .load_pc (redirect_pc),
        .inc     (accept),
        .pc      (pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            if (outstanding) begin
                state_nxt = ST_DRAIN;
            end else if (redir_bad) begin
                state_nxt = ST_ERR;
            end else begin
                state_nxt = ST_REQ;
            end
        end else begin
            unique case (state)
                ST_IDLE:  state_nxt = ST_REQ;
                ST_REQ:   state_nxt = ST_REQ;
                // fetch_err already reflects the latest redirect target
                ST_DRAIN: if (mem_ack) state_nxt = fetch_err ? ST_ERR : ST_REQ;
                ST_ERR:   state_nxt = ST_ERR;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            pc_out      <= 32'h0000_0000;
            fetch_err   <= 1'b0;
            drain_addr  <= RESET_PC;
        end else if (redirect) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_err   <= redir_bad;
            // keeps the abandoned address on the bus while draining
            drain_addr  <= mem_addr;
        end else if (accept) begin
            instr_valid <= 1'b1;
            instr       <= mem_rdata;
            pc_out      <= pc;
        end else if (xfer) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
        end
    end

endmodule
